// File: rtl/trace_pkg.sv
// Shared state encoding and entry sizing for the trace capture block.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int OVF_W = 8;

   // Entry layout is {cycle stamp, change mask, probe snapshot}.
   function automatic int entry_w(input int cycle_w, input int channels, input int data_w);
      return cycle_w + channels + channels * data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace buffer: DEPTH x WIDTH FIFO with wrap-bit pointers; a pop frees room for a same-cycle push when full.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     pushed
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             pop_ok_s;

   assign empty    = (wr_ptr_r == rd_ptr_r);
   assign full     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign level    = wr_ptr_r - rd_ptr_r;
   assign pop_ok_s = pop && !empty && !clear;
   assign pushed   = push && !clear && (!full || pop_ok_s);

   // Pointer update; clear flushes the buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (pushed)   wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (pushed) mem_r[wr_ptr_r[AW-1:0]] <= din;
   end

   // Head entry, forced to zero when nothing is stored
   always_comb begin
      if (empty) dout = {WIDTH{1'b0}};
      else       dout = mem_r[rd_ptr_r[AW-1:0]];
   end

endmodule

// File: rtl/trace_capture.sv
// Trace capture: logs probe-bus changes with a cycle stamp into a drainable FIFO.
// Defining TRACE_TRIGGER_EN adds the trig_value port, the ARMED state and post-trigger count to DONE.
module trace_capture
   import trace_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 5,
   parameter int DEPTH    = 16,
   parameter int CYCLE_W  = 8,
   parameter int POST_CNT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clear,
   input  logic [CHANNELS*DATA_W-1:0]   ch_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CYCLE_W-1:0]           out_cycle,
   output logic [CHANNELS-1:0]          out_mask,
   output logic [CHANNELS*DATA_W-1:0]   out_data,
   output logic [$clog2(DEPTH):0]       level,
   output logic [OVF_W-1:0]             overflow_cnt,
   output logic                         busy
`ifdef TRACE_TRIGGER_EN
   ,
   input  logic [DATA_W-1:0]            trig_value
`endif
);
   localparam int ENTRY_W = entry_w(CYCLE_W, CHANNELS, DATA_W);
   localparam logic [CYCLE_W-1:0] CYC_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};
`ifdef TRACE_TRIGGER_EN
   localparam state_t START_ST = ST_ARMED;
`else
   localparam state_t START_ST = ST_CAPTURE;
`endif

   state_t                       state_r;
   state_t                       next_state_s;
   logic [CYCLE_W-1:0]           cycle_r;
   logic [CHANNELS*DATA_W-1:0]   prev_r;
   logic                         first_r;
   logic                         busy_r;
   logic [OVF_W-1:0]             ovf_r;
   logic [CHANNELS-1:0]          diff_s;
   logic [CHANNELS-1:0]          mask_s;
   logic                         force_s;
   logic                         push_s;
   logic                         pushed_s;
   logic                         full_s;
   logic                         empty_s;
   logic                         trig_hit_s;
   logic                         post_done_s;
   logic [ENTRY_W-1:0]           head_s;

`ifdef TRACE_TRIGGER_EN
   localparam logic [15:0] POST_LIM = 16'(POST_CNT);
   logic [15:0] post_cnt_r;
   logic [15:0] post_total_s;

   assign trig_hit_s   = (state_r == ST_ARMED) && (ch_data[DATA_W-1:0] == trig_value);
   assign post_total_s = post_cnt_r + {15'd0, pushed_s};
   assign post_done_s  = (post_total_s >= POST_LIM);

   // Accepted pushes since the trigger; dropped entries do not count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              post_cnt_r <= 16'd0;
      else if (clear || state_r == ST_IDLE)  post_cnt_r <= 16'd0;
      else                                   post_cnt_r <= post_total_s;
   end
`else
   assign trig_hit_s  = 1'b0;
   assign post_done_s = 1'b0;
`endif

   // State register plus flags derived from the transition
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         first_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         first_r <= (state_r == ST_IDLE) && (next_state_s == ST_CAPTURE);
         busy_r  <= (next_state_s == ST_ARMED) || (next_state_s == ST_CAPTURE);
      end
   end

   // Next-state logic; clear wins over everything
   always_comb begin
      next_state_s = state_r;
      if (clear) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:    if (en) next_state_s = START_ST; else next_state_s = ST_IDLE;
            ST_ARMED:   if (trig_hit_s) next_state_s = post_done_s ? ST_DONE : ST_CAPTURE;
                        else next_state_s = ST_ARMED;
            ST_CAPTURE: if (post_done_s) next_state_s = ST_DONE; else next_state_s = ST_CAPTURE;
            ST_DONE:    next_state_s = ST_DONE;
            default:    next_state_s = ST_IDLE;
         endcase
      end
   end

   // Change detection and push decision
   always_comb begin
      diff_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         diff_s[i] = (ch_data[i*DATA_W +: DATA_W] != prev_r[i*DATA_W +: DATA_W]);
      end
      force_s = trig_hit_s || ((state_r == ST_CAPTURE) && first_r);
      if (force_s) mask_s = {CHANNELS{1'b1}};
      else         mask_s = diff_s;
      if (clear) push_s = 1'b0;
      else       push_s = force_s || ((state_r == ST_CAPTURE) && (|diff_s));
   end

   // Free-running cycle stamp
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       cycle_r <= {CYCLE_W{1'b0}};
      else if (clear) cycle_r <= {CYCLE_W{1'b0}};
      else            cycle_r <= cycle_r + CYC_ONE;
   end

   // Previous probe snapshot, tracked while armed or capturing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                             prev_r <= {(CHANNELS*DATA_W){1'b0}};
      else if (clear)                                       prev_r <= {(CHANNELS*DATA_W){1'b0}};
      else if (state_r == ST_ARMED || state_r == ST_CAPTURE) prev_r <= ch_data;
      else                                                  prev_r <= prev_r;
   end

   // Saturating count of entries lost to a full buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                             ovf_r <= 8'd0;
      else if (clear)                                       ovf_r <= 8'd0;
      else if (push_s && full_s && !pushed_s && ovf_r != 8'hFF) ovf_r <= ovf_r + 8'd1;
      else                                                  ovf_r <= ovf_r;
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .push   (push_s),
      .pop    (out_ready),
      .din    ({cycle_r, mask_s, ch_data}),
      .dout   (head_s),
      .full   (full_s),
      .empty  (empty_s),
      .level  (level),
      .pushed (pushed_s)
   );

   assign out_valid                         = !empty_s;
   assign {out_cycle, out_mask, out_data}   = head_s;
   assign overflow_cnt                      = ovf_r;
   assign busy                              = busy_r;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture (DEPTH=4, CYCLE_W=4); trigger test only when TRACE_TRIGGER_EN is defined.
module tb_trace_capture;
   localparam int DW = 32;
   localparam int CH = 5;
   localparam int DEPTH = 4;
   localparam int CW = 4;
   localparam int PC = 3;
   localparam int EW = CW + CH + CH * DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic clear = 1'b0;
   logic out_ready = 1'b0;
   logic [CH*DW-1:0] ch_data = '0;
   logic out_valid;
   logic [CW-1:0] out_cycle;
   logic [CH-1:0] out_mask;
   logic [CH*DW-1:0] out_data;
   logic [$clog2(DEPTH):0] level;
   logic [7:0] overflow_cnt;
   logic busy;
   logic [DW-1:0] trig_value = '0;

   int errors = 0;
   int checks = 0;
   logic [EW-1:0] exp_q[$];

   trace_capture #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DEPTH), .CYCLE_W(CW), .POST_CNT(PC)) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .ch_data(ch_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle), .out_mask(out_mask),
      .out_data(out_data), .level(level), .overflow_cnt(overflow_cnt), .busy(busy)
`ifdef TRACE_TRIGGER_EN
      , .trig_value(trig_value)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT just out of reset with its cycle counter at 0.
   task automatic apply_reset();
      en = 1'b0; clear = 1'b0; out_ready = 1'b0; ch_data = '0; rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [EW+13:0] all_out;
      en = 1'b0; clear = 1'b0; out_ready = 1'b0; ch_data = '0; rst = 1'b0;
      tick(); tick();
      all_out = {out_valid, busy, level, overflow_cnt, out_cycle, out_mask, out_data};
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", all_out); end
      rst = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin ch_data[31:0] = 32'(k + 1); tick(); end
      checks++;
      if (level !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset_fill level=%0d busy=%0d exp 3,1", level, busy); end
      rst = 1'b0;
      #2;
      all_out = {out_valid, busy, level, overflow_cnt, out_cycle, out_mask, out_data};
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL async_reset got %h exp 0", all_out); end
      tick();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin ch_data[63:0] = {$urandom(), $urandom()}; tick(); end
      checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_no_log level=%0d valid=%0d busy=%0d exp 0,0,0", level, out_valid, busy);
      end
   endtask

   task automatic test_change_log();
      logic [CH*DW-1:0] d;
      apply_reset();
      out_ready = 1'b1; d = '0;
      for (int c = 0; c < 12; c++) begin
         en = (c == 2);
         if (c == 3) begin d[31:0] = 32'h2002_0005; exp_q.push_back({4'd3, 5'b11111, d}); end
         if (c == 6) begin d[63:32] = 32'd7; exp_q.push_back({4'd6, 5'b00010, d}); end
         ch_data = d;
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL change_log unexpected entry cycle=%0d", out_cycle); end
            else begin
               if ({out_cycle, out_mask, out_data} !== exp_q[0]) begin
                  errors++; $display("FAIL change_log entry got %h exp %h", {out_cycle, out_mask, out_data}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL change_log missing=%0d exp 0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      logic [CH*DW-1:0] d;
      apply_reset();
      d = '0;
      for (int c = 0; c < 15; c++) begin
         en = (c == 0);
         out_ready = (c >= 7);
         if (c >= 1 && c <= 7) begin
            d[31:0] = 32'(100 + c);
            if (c <= 4 || c == 7) exp_q.push_back({4'(c), (c == 1) ? 5'b11111 : 5'b00001, d});
         end
         ch_data = d;
         @(negedge clk);
         if (c == 5) begin
            checks++;
            if (out_cycle !== 4'd1) begin errors++; $display("FAIL head_stable cycle=%0d exp 1", out_cycle); end
         end
         if (c == 7 || c == 8) begin
            checks++;
            if (level !== 3'd4 || overflow_cnt !== 8'd2) begin
               errors++; $display("FAIL overflow c=%0d level=%0d ovf=%0d exp 4,2", c, level, overflow_cnt);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL overflow unexpected entry cycle=%0d", out_cycle); end
            else begin
               if ({out_cycle, out_mask, out_data} !== exp_q[0]) begin
                  errors++; $display("FAIL overflow entry got %h exp %h", {out_cycle, out_mask, out_data}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || level !== 3'd0 || overflow_cnt !== 8'd2) begin
         errors++; $display("FAIL overflow_end missing=%0d level=%0d ovf=%0d exp 0,0,2", exp_q.size(), level, overflow_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [CH*DW-1:0] d;
      apply_reset();
      out_ready = 1'b1; d = '0;
      for (int c = 0; c < 22; c++) begin
         en = (c == 13);
         if (c >= 14 && c <= 17) begin
            d[95:64] = 32'(c + 1);
            exp_q.push_back({4'(c), (c == 14) ? 5'b11111 : 5'b00100, d});
         end
         ch_data = d;
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL wrap unexpected entry cycle=%0d", out_cycle); end
            else begin
               if ({out_cycle, out_mask, out_data} !== exp_q[0]) begin
                  errors++; $display("FAIL wrap entry got %h exp %h", {out_cycle, out_mask, out_data}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL wrap missing=%0d exp 0", exp_q.size()); end
   endtask

   task automatic test_clear();
      logic [CH*DW-1:0] d;
      apply_reset();
      d = '0;
      for (int c = 0; c < 14; c++) begin
         en = (c == 0) || (c == 6) || (c == 8);
         clear = (c == 6);
         out_ready = (c >= 9);
         if (c >= 1 && c <= 6) d[31:0] = 32'(200 + c);
         if (c == 9) begin d[159:128] = 32'hCAFE_0001; exp_q.push_back({4'd2, 5'b11111, d}); end
         ch_data = d;
         @(negedge clk);
         if (c == 6) begin
            checks++;
            if (overflow_cnt !== 8'd1 || out_cycle !== 4'd1 || level !== 3'd4) begin
               errors++; $display("FAIL pre_clear ovf=%0d head=%0d level=%0d exp 1,1,4", overflow_cnt, out_cycle, level);
            end
         end
         if (c == 7) begin
            checks++;
            if (level !== 3'd0 || out_valid !== 1'b0 || overflow_cnt !== 8'd0 || busy !== 1'b0) begin
               errors++; $display("FAIL clear level=%0d valid=%0d ovf=%0d busy=%0d exp 0,0,0,0", level, out_valid, overflow_cnt, busy);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL clear unexpected entry cycle=%0d", out_cycle); end
            else begin
               if ({out_cycle, out_mask, out_data} !== exp_q[0]) begin
                  errors++; $display("FAIL clear entry got %h exp %h", {out_cycle, out_mask, out_data}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL clear_restart missing=%0d busy=%0d exp 0,1", exp_q.size(), busy); end
   endtask

`ifdef TRACE_TRIGGER_EN
   task automatic test_trigger();
      logic [CH*DW-1:0] d;
      apply_reset();
      trig_value = 32'h0000_0020; d = '0;
      for (int c = 0; c < 19; c++) begin
         en = (c == 1) || (c == 16);
         clear = (c == 16);
         out_ready = (c == 14) || (c == 15);
         if (c <= 15) d[31:0] = 32'h17 + 32'(c);
         if (c >= 9 && c <= 11) exp_q.push_back({4'(c), (c == 9) ? 5'b11111 : 5'b00001, d});
         ch_data = d;
         @(negedge clk);
         if (c == 5) begin
            checks++;
            if (busy !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL armed busy=%0d level=%0d exp 1,0", busy, level); end
         end
         if (c == 13) begin
            checks++;
            if (busy !== 1'b0 || level !== 3'd3) begin errors++; $display("FAIL done busy=%0d level=%0d exp 0,3", busy, level); end
         end
         if (c == 17) begin
            checks++;
            if (busy !== 1'b0 || level !== 3'd0 || out_valid !== 1'b0) begin
               errors++; $display("FAIL trig_clear busy=%0d level=%0d valid=%0d exp 0,0,0", busy, level, out_valid);
            end
            exp_q.delete();
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL trigger unexpected entry cycle=%0d", out_cycle); end
            else begin
               if ({out_cycle, out_mask, out_data} !== exp_q[0]) begin
                  errors++; $display("FAIL trigger entry got %h exp %h", {out_cycle, out_mask, out_data}, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_change_log();
      test_overflow();
      test_wrap();
      test_clear();
`ifdef TRACE_TRIGGER_EN
      test_trigger();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
